// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: sends one byte with odd parity and drives the pins as open-drain enables.
// Optional build macro PS2_TX_ACK_CHECK_EN: a missing device acknowledge ends the frame with error instead of done.
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE
    } state_t;

    state_t           state_q;
    logic [2:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [2:0]       bit_cnt_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic             tmo_expired;
    logic             cmd_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             clk_oe_q;
    logic             dat_oe_q;
`ifdef PS2_TX_ACK_CHECK_EN
    logic             ack_q;
`endif

    logic clk_s;
    logic dat_s;
    logic fall;

    // Bit 2 of the clock chain holds the previous synchronized level for edge detection.
    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fall  = clk_sync_q[2] & ~clk_sync_q[1];

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q + 1'b1;
        tmo_expired = (tmo_cnt_q == TMO_LAST);
    end

    // Idle bus level is high, so the synchronizers reset to 1 to avoid a false fall after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            clk_oe_q    <= 1'b0;
            dat_oe_q    <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q       <= 1'b1;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        shift_q     <= cmd_data;
                        parity_q    <= ~^cmd_data;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        clk_oe_q    <= 1'b1;
                        inh_cnt_q   <= '0;
                        state_q     <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt_q == INH_LAST) begin
                        clk_oe_q  <= 1'b0;
                        dat_oe_q  <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= START;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                    end
                end
                default: begin
                    // Device-clocked states: the gap timer beats any fall seen in the same cycle.
                    if (tmo_expired) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        error_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        tmo_cnt_q <= fall ? '0 : tmo_cnt_d;
                        case (state_q)
                            START: if (fall) begin
                                dat_oe_q  <= ~shift_q[0];
                                shift_q   <= shift_q >> 1;
                                bit_cnt_q <= '0;
                                state_q   <= DATA;
                            end
                            DATA: if (fall) begin
                                if (bit_cnt_q == 3'd7) begin
                                    dat_oe_q <= ~parity_q;
                                    state_q  <= PARITY;
                                end else begin
                                    dat_oe_q  <= ~shift_q[0];
                                    shift_q   <= shift_q >> 1;
                                    bit_cnt_q <= bit_cnt_q + 1'b1;
                                end
                            end
                            PARITY: if (fall) begin
                                dat_oe_q <= 1'b0;
                                state_q  <= STOP;
                            end
                            STOP: if (fall) begin
                                state_q <= ACK;
                            end
                            ACK: if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                                ack_q   <= dat_s;
`endif
                                state_q <= WAIT_IDLE;
                            end
                            WAIT_IDLE: if (clk_s && dat_s) begin
`ifdef PS2_TX_ACK_CHECK_EN
                                done_q  <= ~ack_q;
                                error_q <= ack_q;
`else
                                done_q  <= 1'b1;
`endif
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Self-checking bench for ps2_command_tx: a PS/2 device model clocks frames out of the DUT and a frame model checks them.
module tb_ps2_command_tx;
    localparam int INH  = 40;
    localparam int TMO  = 300;
    localparam int HALF = 20;

    logic       clock;
    logic       resetn;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       dev_clk_low;
    logic       dev_dat_low;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       scramble;

    int errors;
    int checks;
    int overlap;

    // Wired-AND open-drain bus with pull-ups.
    assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat = ~(ps2_dat_oe | dev_dat_low);

    ps2_command_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .ps2_clk_in(ps2_clk),
        .ps2_dat_in(ps2_dat),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (scramble) cmd_data = 8'($urandom);
        if (resetn && busy && cmd_ready) overlap++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    // Frame as seen on the data line: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic bit expect_error(input bit acked);
`ifdef PS2_TX_ACK_CHECK_EN
        return !acked;
`else
        return 1'b0 && acked;
`endif
    endfunction

    task automatic send_cmd(input logic [7:0] b, input bit hold, output logic first_oe, output int inh_len);
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge clock);
        scramble = hold;
        if (!hold) cmd_valid = 1'b0;
        first_oe = ps2_clk_oe;
        inh_len  = 0;
        while (ps2_clk_oe === 1'b1 && inh_len < 4 * INH) begin
            inh_len++;
            @(negedge clock);
        end
    endtask

    task automatic device(input int nfalls, input bit do_ack, output logic [10:0] frame);
        frame = '1;
        for (int i = 0; i < nfalls && i < 11; i++) begin
            repeat (HALF) @(negedge clock);
            frame[i]    = ps2_dat;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b0;
        end
        if (nfalls > 11) begin
            repeat (HALF) @(negedge clock);
            dev_dat_low = do_ack;
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clock);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic watch_end(output int n_done, output int n_err, output logic rdy_p, output logic rdy_a);
        bit seen;
        bit just;
        n_done = 0;
        n_err  = 0;
        rdy_p  = 1'bx;
        rdy_a  = 1'bx;
        seen   = 0;
        just   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done === 1'b1 || error === 1'b1) begin
                if (!seen) begin
                    rdy_p = cmd_ready;
                    seen  = 1;
                    just  = 1;
                end
            end else if (just) begin
                rdy_a = cmd_ready;
                just  = 0;
            end
            if (cmd_ready === 1'b1) cmd_valid = 1'b0;
            if (done === 1'b1) n_done++;
            if (error === 1'b1) n_err++;
        end
    endtask

    task automatic test_frame(input string name, input logic [7:0] b, input bit acked, input bit hold);
        int         inh_len;
        logic       first_oe;
        logic [10:0] frame;
        logic [10:0] exp_frame;
        int         n_done;
        int         n_err;
        logic       rdy_p;
        logic       rdy_a;
        bit         exp_err;
        send_cmd(b, hold, first_oe, inh_len);
        checks++;
        if (first_oe !== 1'b1) begin
            errors++;
            $display("FAIL %s clk_oe_latency: got %b expected 1", name, first_oe);
        end
        checks++;
        if (inh_len != INH) begin
            errors++;
            $display("FAIL %s inhibit_len: got %0d expected %0d", name, inh_len, INH);
        end
        checks++;
        if (ps2_dat_oe !== 1'b1) begin
            errors++;
            $display("FAIL %s start_dat_oe: got %b expected 1", name, ps2_dat_oe);
        end
        device(12, acked, frame);
        exp_frame = model_frame(b);
        checks++;
        if (frame !== exp_frame) begin
            errors++;
            $display("FAIL %s frame: got %b expected %b", name, frame, exp_frame);
        end
        watch_end(n_done, n_err, rdy_p, rdy_a);
        scramble = 1'b0;
        cmd_valid = 1'b0;
        exp_err  = expect_error(acked);
        checks++;
        if (n_done != (exp_err ? 0 : 1)) begin
            errors++;
            $display("FAIL %s done_count: got %0d expected %0d", name, n_done, exp_err ? 0 : 1);
        end
        checks++;
        if (n_err != (exp_err ? 1 : 0)) begin
            errors++;
            $display("FAIL %s error_count: got %0d expected %0d", name, n_err, exp_err ? 1 : 0);
        end
        checks++;
        if (rdy_p !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_at_pulse: got %b expected 0", name, rdy_p);
        end
        checks++;
        if (rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after_pulse: got %b expected 1", name, rdy_a);
        end
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        cmd_valid   = 1'b0;
        cmd_data    = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        scramble    = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({cmd_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 100000",
                     {cmd_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe});
        end
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({cmd_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe} !== 6'b100000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 100000",
                     {cmd_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_timeout();
        int          inh_len;
        logic        first_oe;
        logic [10:0] frame;
        int          cnt;
        send_cmd(8'($urandom), 1'b0, first_oe, inh_len);
        device(3, 1'b0, frame);
        repeat (HALF) @(negedge clock);
        dev_clk_low = 1'b1;
        cnt = 0;
        while (error !== 1'b1 && cnt < 2 * TMO) begin
            @(posedge clock);
            #1;
            cnt++;
            if (cnt == HALF) dev_clk_low = 1'b0;
        end
        dev_clk_low = 1'b0;
        checks++;
        if (cnt != TMO + 3) begin
            errors++;
            $display("FAIL timeout_delay: got %0d expected %0d", cnt, TMO + 3);
        end
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, done} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_lines: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, done});
        end
        @(posedge clock);
        #1;
        checks++;
        if ({cmd_ready, error, busy} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_after: got %b expected 100", {cmd_ready, error, busy});
        end
    endtask

    task automatic test_reset_mid_frame();
        int          inh_len;
        logic        first_oe;
        logic [10:0] frame;
        send_cmd(8'h5A, 1'b0, first_oe, inh_len);
        device(3, 1'b0, frame);
        repeat (5) @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset_release: got %b expected 0001",
                     {ps2_clk_oe, ps2_dat_oe, busy, cmd_ready});
        end
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        test_frame("ff_after_reset", 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_frame("held_valid", 8'h3C, 1'b1, 1'b1);
        repeat (5) @(negedge clock);
        checks++;
        if ({busy, ps2_clk_oe, cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL held_valid_no_requeue: got %b expected 001", {busy, ps2_clk_oe, cmd_ready});
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL ready_while_busy: got %0d cycles expected 0", overlap);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            test_frame("random", 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        overlap = 0;
        test_reset();
        test_frame("cmd_ed", 8'hED, 1'b1, 1'b0);
        test_frame("cmd_02", 8'h02, 1'b1, 1'b0);
        test_frame("no_ack", 8'hA7, 1'b0, 1'b0);
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
